// File: rtl/packing_aligner.sv
`default_nettype none
// ============================================================================
// Module   : packing_aligner
// Packs variable-length compressed beats into OUT_W-bit words through a
// multi-word accumulation buffer; bypass beats pass through with tag stripped.
// Build option: PACKING_ALIGNER_STATS_EN instantiates the stat_* counters.
// Revision : 1.0 - initial release
// ============================================================================
module packing_aligner #(
    parameter int IN_W  = 272,
    parameter int TAG_W = 16,
    parameter int LEN_W = 8,
    parameter int OUT_W = 256,
    parameter int BUF_W = 576
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_data,
    input  logic [LEN_W-1:0]           in_len,
    input  logic                       in_last,
    input  logic                       in_bypass,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(OUT_W/8):0]   out_bytes,
    output logic                       out_last,
    output logic [31:0]                stat_words,
    output logic [31:0]                stat_stall
);

    localparam int c_IB       = IN_W / 8;
    localparam int c_OB       = OUT_W / 8;
    localparam int c_BB       = BUF_W / 8;
    localparam int c_FILL_W   = $clog2(c_BB + 1);
    localparam int c_OBYTES_W = $clog2(c_OB) + 1;

    localparam logic [c_FILL_W-1:0]   c_OB_F     = c_FILL_W'(c_OB);
    localparam logic [c_FILL_W-1:0]   c_ROOM_F   = c_FILL_W'(c_BB - c_IB);
    localparam logic [c_FILL_W-1:0]   c_IB_F     = c_FILL_W'(c_IB);
    localparam logic [c_OBYTES_W-1:0] c_OB_BYTES = c_OBYTES_W'(c_OB);

    typedef enum logic [1:0] {
        S_ACCUM  = 2'd0,
        S_FLUSH  = 2'd1,
        S_PREBYP = 2'd2,
        S_BYPASS = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_FILL_W-1:0]  r_fill;
    logic [BUF_W-1:0]     r_buf;
    logic [OUT_W-1:0]     r_byp_data;
    logic                 r_byp_last;

    logic [c_FILL_W-1:0]  w_len;
    logic [IN_W-1:0]      w_in_masked;
    logic [c_FILL_W-1:0]  w_base;
    logic [c_FILL_W-1:0]  w_fill_nxt;
    logic [BUF_W-1:0]     w_ins;
    logic [BUF_W-1:0]     w_buf_nxt;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_acc_cmp;
    logic                 w_out_fire;
    logic                 w_drain;
    logic                 w_byp_hold;

    always_comb begin
        if (32'(in_len) > 32'(c_IB)) begin
            w_len = c_IB_F;
        end else begin
            w_len = c_FILL_W'(in_len);
        end
        w_in_masked = '0;
        for (int i = 0; i < c_IB; i++) begin
            if (i < int'(w_len)) begin
                w_in_masked[8*i +: 8] = in_data[8*i +: 8];
            end
        end
    end

    // Output word is a pure function of registered state and buffer.
    always_comb begin
        out_valid = 1'b0;
        out_bytes = '0;
        out_last  = 1'b0;
        out_data  = r_buf[OUT_W-1:0];
        case (r_state)
            S_ACCUM: begin
                if (r_fill >= c_OB_F) begin
                    out_valid = 1'b1;
                    out_bytes = c_OB_BYTES;
                end
            end
            S_FLUSH: begin
                out_valid = 1'b1;
                if (r_fill >= c_OB_F) begin
                    out_bytes = c_OB_BYTES;
                end else begin
                    out_bytes = c_OBYTES_W'(r_fill);
                    out_last  = 1'b1;
                end
            end
            S_PREBYP: begin
                if (r_fill != '0) begin
                    out_valid = 1'b1;
                    out_bytes = (r_fill >= c_OB_F) ? c_OB_BYTES : c_OBYTES_W'(r_fill);
                end
            end
            S_BYPASS: begin
                out_valid = 1'b1;
                out_bytes = c_OB_BYTES;
                out_last  = r_byp_last;
                out_data  = r_byp_data;
            end
            default: ;
        endcase
    end

    // A bypass beat waiting behind residue is held off until PREBYP drains it.
    assign w_byp_hold = in_valid && in_bypass && (r_fill != '0);
    assign w_in_ready = (r_state == S_ACCUM) && (r_fill <= c_ROOM_F) && !reset && !w_byp_hold;
    assign in_ready   = w_in_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_acc_cmp  = w_accept && !in_bypass;
    assign w_out_fire = out_valid && out_ready;
    assign w_drain    = w_out_fire && (r_state != S_BYPASS);

    always_comb begin
        w_base = r_fill;
        if (w_drain) begin
            w_base = (r_fill >= c_OB_F) ? (r_fill - c_OB_F) : '0;
        end
        w_fill_nxt = w_base + (w_acc_cmp ? w_len : '0);
        w_ins      = BUF_W'(w_in_masked) << {w_base, 3'b000};
        w_buf_nxt  = (w_drain ? (r_buf >> OUT_W) : r_buf) | (w_acc_cmp ? w_ins : '0);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACCUM: begin
                if (w_accept) begin
                    if (in_bypass) begin
                        w_state_nxt = S_BYPASS;
                    end else if (in_last) begin
                        w_state_nxt = S_FLUSH;
                    end
                end else if (w_byp_hold) begin
                    w_state_nxt = S_PREBYP;
                end
            end
            S_FLUSH: begin
                if (w_out_fire && (r_fill < c_OB_F)) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_PREBYP: begin
                if ((r_fill == '0) || (w_out_fire && (r_fill <= c_OB_F))) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_BYPASS: begin
                if (w_out_fire) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            default: w_state_nxt = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_ACCUM;
            r_fill     <= '0;
            r_buf      <= '0;
            r_byp_data <= '0;
            r_byp_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            r_buf   <= w_buf_nxt;
            if (w_accept && in_bypass) begin
                r_byp_data <= OUT_W'(in_data >> TAG_W);
                r_byp_last <= in_last;
            end
        end
    end

`ifdef PACKING_ALIGNER_STATS_EN
    logic [31:0] r_stat_words;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_words <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_out_fire) begin
                r_stat_words <= r_stat_words + 32'd1;
            end
            if (out_valid && !out_ready) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_words = r_stat_words;
    assign stat_stall = r_stat_stall;
`else
    assign stat_words = '0;
    assign stat_stall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_packing_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_packing_aligner
// Directed self-checking bench for packing_aligner at default parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packing_aligner;

    localparam int IN_W  = 272;
    localparam int OUT_W = 256;
    localparam int IB    = IN_W / 8;
    localparam int OB    = OUT_W / 8;

    typedef logic [255:0] w256_t;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [7:0]        in_len;
    logic              in_last;
    logic              in_bypass;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [5:0]        out_bytes;
    logic              out_last;
    logic [31:0]       stat_words;
    logic [31:0]       stat_stall;

    int n_total = 0;
    int n_bad   = 0;

    logic [OUT_W-1:0] q_data[$];
    int               q_bytes[$];
    bit               q_last[$];

    packing_aligner dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len     (in_len),
        .in_last    (in_last),
        .in_bypass  (in_bypass),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bytes  (out_bytes),
        .out_last   (out_last),
        .stat_words (stat_words),
        .stat_stall (stat_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes seen at the falling edge complete on the following rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_bytes.push_back(int'(out_bytes));
            q_last.push_back(out_last);
        end
    end

    task automatic chk(input string tag, input w256_t obs, input w256_t exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] make_beat(input int first, input int len);
        logic [IN_W-1:0] v;
        for (int i = 0; i < IB; i++) begin
            v[8*i +: 8] = (i < len) ? 8'(first + i) : 8'hEE;
        end
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] make_word(input int first, input int nbytes);
        logic [OUT_W-1:0] v;
        for (int i = 0; i < OB; i++) begin
            v[8*i +: 8] = (i < nbytes) ? 8'(first + i) : 8'h00;
        end
        return v;
    endfunction

    task automatic drive(input logic [IN_W-1:0] d, input int len, input bit last, input bit byp);
        in_data   = d;
        in_len    = 8'(len);
        in_last   = last;
        in_bypass = byp;
        in_valid  = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " accept"}, w256_t'(in_ready), w256_t'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [IN_W-1:0] d, input int len, input bit last, input bit byp,
                        input string tag);
        drive(d, len, last, byp);
        wait_accept(tag);
    endtask

    task automatic wait_words(input int n, input string tag);
        int k;
        k = 0;
        while (q_data.size() < n && k < 500) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " count"}, w256_t'(q_data.size()), w256_t'(n));
    endtask

    task automatic check_word(input string tag, input logic [OUT_W-1:0] d, input int nb,
                              input bit last);
        if (q_data.size() > 0) begin
            chk({tag, " data"},  w256_t'(q_data.pop_front()),  w256_t'(d));
            chk({tag, " bytes"}, w256_t'(q_bytes.pop_front()), w256_t'(nb));
            chk({tag, " last"},  w256_t'(q_last.pop_front()),  w256_t'(last));
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_bytes.delete();
        q_last.delete();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        clear_q();
    endtask

    initial begin
        logic [IN_W-1:0] byp;
        int              exp_words;
        int              exp_stall;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        in_last   = 1'b0;
        in_bypass = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst out_valid",  w256_t'(out_valid),  w256_t'(0));
        chk("rst in_ready",   w256_t'(in_ready),   w256_t'(0));
        chk("rst out_bytes",  w256_t'(out_bytes),  w256_t'(0));
        chk("rst out_last",   w256_t'(out_last),   w256_t'(0));
        chk("rst out_data",   w256_t'(out_data),   w256_t'(0));
        chk("rst stat_words", w256_t'(stat_words), w256_t'(0));
        chk("rst stat_stall", w256_t'(stat_stall), w256_t'(0));
        do_reset();
        chk("post-rst in_ready", w256_t'(in_ready), w256_t'(1));

        // Packing: 8 x 20 bytes -> five full words, then an empty last word
        for (int k = 0; k < 8; k++) begin
            send(make_beat(20 * k, 20), 20, (k == 7), 1'b0, "pack");
        end
        wait_words(6, "pack");
        for (int w = 0; w < 5; w++) begin
            check_word($sformatf("pack w%0d", w), make_word(32 * w, 32), 32, 1'b0);
        end
        check_word("pack tail", '0, 0, 1'b1);

        // Partial tail: 34 (len over-range, clamped), 34, 5
        send(make_beat(0, 34), 200, 1'b0, 1'b0, "tail");
        send(make_beat(34, 34), 34, 1'b0, 1'b0, "tail");
        send(make_beat(68, 5), 5, 1'b1, 1'b0, "tail");
        wait_words(3, "tail");
        check_word("tail w0", make_word(0, 32), 32, 1'b0);
        check_word("tail w1", make_word(32, 32), 32, 1'b0);
        check_word("tail w2", make_word(64, 9), 9, 1'b1);

        // Backpressure
        out_ready = 1'b0;
        send(make_beat(0, 34), 34, 1'b0, 1'b0, "bp");
        send(make_beat(34, 34), 34, 1'b0, 1'b0, "bp");
        drive(make_beat(68, 34), 34, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp in_ready",  w256_t'(in_ready),  w256_t'(0));
            chk("bp out_valid", w256_t'(out_valid), w256_t'(1));
            chk("bp out_data",  w256_t'(out_data),  w256_t'(make_word(0, 32)));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept("bp");
        wait_words(4, "bp");
        check_word("bp w0", make_word(0, 32), 32, 1'b0);
        check_word("bp w1", make_word(32, 32), 32, 1'b0);
        check_word("bp w2", make_word(64, 32), 32, 1'b0);
        check_word("bp w3", make_word(96, 6), 6, 1'b1);

        // Bypass after 10 bytes of residue, tag 0xABCD
        send(make_beat(8'hA0, 10), 10, 1'b0, 1'b0, "byp");
        byp = '0;
        byp[15:0] = 16'hABCD;
        for (int i = 2; i < IB; i++) begin
            byp[8*i +: 8] = 8'(8'h30 + i);
        end
        drive(byp, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("byp held", w256_t'(in_ready), w256_t'(0));
        wait_accept("byp");
        wait_words(2, "byp");
        check_word("byp residue", make_word(8'hA0, 10), 10, 1'b0);
        check_word("byp word", make_word(8'h32, 32), 32, 1'b0);

        // Asynchronous reset with 25 bytes buffered
        send(make_beat(1, 25), 25, 1'b0, 1'b0, "arst");
        #3;
        reset = 1'b1;
        #1;
        chk("arst out_valid", w256_t'(out_valid), w256_t'(0));
        chk("arst in_ready",  w256_t'(in_ready),  w256_t'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        clear_q();
        send(make_beat(8'h80, 32), 32, 1'b1, 1'b0, "arst");
        wait_words(2, "arst");
        check_word("arst w0", make_word(8'h80, 32), 32, 1'b0);
        check_word("arst tail", '0, 0, 1'b1);

        // Statistics: 3 words, 4 stall cycles
        do_reset();
        out_ready = 1'b0;
        send(make_beat(0, 34), 34, 1'b0, 1'b0, "stat");
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(make_beat(34, 34), 34, 1'b1, 1'b0, "stat");
        wait_words(3, "stat");
        check_word("stat w0", make_word(0, 32), 32, 1'b0);
        check_word("stat w1", make_word(32, 32), 32, 1'b0);
        check_word("stat w2", make_word(64, 4), 4, 1'b1);
`ifdef PACKING_ALIGNER_STATS_EN
        exp_words = 3;
        exp_stall = 4;
`else
        exp_words = 0;
        exp_stall = 0;
`endif
        chk("stat_words", w256_t'(stat_words), w256_t'(exp_words));
        chk("stat_stall", w256_t'(stat_stall), w256_t'(exp_stall));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
